// File: rtl/rggen_bus_arbiter_pkg.sv
// ============================================================================
// Module   : rggen_bus_arbiter_pkg
// Brief    : Shared rggen bus access codes and arbiter state encodings.
// Revision : 1.0
// ============================================================================
`default_nettype none

package rggen_bus_arbiter_pkg;

    localparam logic [1:0] RGGEN_WRITE = 2'b11;
    localparam logic [1:0] RGGEN_READ  = 2'b10;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'b00,
        ARB_BUSY    = 2'b01,
        ARB_RESPOND = 2'b10
    } arb_state_e;

endpackage

`default_nettype wire

// File: rtl/rggen_bus_arbiter_rr_picker.sv
// ============================================================================
// Module   : rggen_bus_arbiter_rr_picker
// Brief    : Combinational round-robin picker, one-hot winner after last grant.
// Revision : 1.0
// ============================================================================
`default_nettype none

module rggen_bus_arbiter_rr_picker #(
    parameter int REQUESTERS = 2
) (
    input  logic [REQUESTERS-1:0] i_request,
    input  logic [REQUESTERS-1:0] i_last_grant,
    output logic [REQUESTERS-1:0] o_winner
);

    int w_last_idx;
    int w_best_idx;
    int w_best_dist;
    int w_dist;

    // Each requester's distance from the slot after the last grant sets its priority.
    always_comb begin
        w_last_idx  = REQUESTERS - 1;
        w_best_idx  = 0;
        w_best_dist = REQUESTERS;
        w_dist      = 0;
        o_winner    = '0;
        for (int i = 0; i < REQUESTERS; i++) begin
            if (i_last_grant[i]) begin
                w_last_idx = i;
            end
        end
        for (int i = 0; i < REQUESTERS; i++) begin
            w_dist = (i + REQUESTERS - w_last_idx - 1) % REQUESTERS;
            if (i_request[i] && (w_dist < w_best_dist)) begin
                w_best_dist = w_dist;
                w_best_idx  = i;
            end
        end
        for (int i = 0; i < REQUESTERS; i++) begin
            o_winner[i] = (w_best_dist < REQUESTERS) && (w_best_idx == i);
        end
    end

endmodule

`default_nettype wire

// File: rtl/rggen_bus_arbiter.sv
// ============================================================================
// Module   : rggen_bus_arbiter
// Brief    : Round-robin sharing of one rggen register bus, one transaction in flight.
// Revision : 1.0
// ============================================================================
`default_nettype none

module rggen_bus_arbiter
    import rggen_bus_arbiter_pkg::*;
#(
    parameter int REQUESTERS    = 2,
    parameter int ADDRESS_WIDTH = 8,
    parameter int BUS_WIDTH     = 32
) (
    input  logic                                 i_clk,
    input  logic                                 i_rst,
    input  logic [REQUESTERS-1:0]                i_req_valid,
    input  logic [2*REQUESTERS-1:0]              i_req_access,
    input  logic [ADDRESS_WIDTH*REQUESTERS-1:0]  i_req_address,
    input  logic [BUS_WIDTH*REQUESTERS-1:0]      i_req_write_data,
    input  logic [BUS_WIDTH/8*REQUESTERS-1:0]    i_req_strobe,
    output logic [REQUESTERS-1:0]                o_req_ready,
    output logic [1:0]                           o_req_status,
    output logic [BUS_WIDTH-1:0]                 o_req_read_data,
    output logic                                 o_bus_valid,
    output logic [1:0]                           o_bus_access,
    output logic [ADDRESS_WIDTH-1:0]             o_bus_address,
    output logic [BUS_WIDTH-1:0]                 o_bus_write_data,
    output logic [BUS_WIDTH/8-1:0]               o_bus_strobe,
    input  logic                                 i_bus_ready,
    input  logic [1:0]                           i_bus_status,
    input  logic [BUS_WIDTH-1:0]                 i_bus_read_data,
    output logic [REQUESTERS-1:0]                o_grant
);

    localparam int                    c_strobe_width    = BUS_WIDTH / 8;
    localparam logic [REQUESTERS-1:0] c_last_grant_init = REQUESTERS'(1) << (REQUESTERS - 1);

    arb_state_e                r_state;
    arb_state_e                w_state_next;
    logic [REQUESTERS-1:0]     r_grant;
    logic [REQUESTERS-1:0]     r_last_grant;
    logic [REQUESTERS-1:0]     w_winner;
    logic                      w_any_valid;

    logic [1:0]                w_sel_access;
    logic [ADDRESS_WIDTH-1:0]  w_sel_address;
    logic [BUS_WIDTH-1:0]      w_sel_write_data;
    logic [c_strobe_width-1:0] w_sel_strobe;

    logic                      r_bus_valid;
    logic [1:0]                r_bus_access;
    logic [ADDRESS_WIDTH-1:0]  r_bus_address;
    logic [BUS_WIDTH-1:0]      r_bus_write_data;
    logic [c_strobe_width-1:0] r_bus_strobe;
    logic [REQUESTERS-1:0]     r_req_ready;
    logic [1:0]                r_req_status;
    logic [BUS_WIDTH-1:0]      r_req_read_data;

    assign w_any_valid = |i_req_valid;

    rggen_bus_arbiter_rr_picker #(
        .REQUESTERS (REQUESTERS)
    ) u_picker (
        .i_request    (i_req_valid),
        .i_last_grant (r_last_grant),
        .o_winner     (w_winner)
    );

    always_comb begin
        w_sel_access     = '0;
        w_sel_address    = '0;
        w_sel_write_data = '0;
        w_sel_strobe     = '0;
        for (int i = 0; i < REQUESTERS; i++) begin
            if (w_winner[i]) begin
                w_sel_access     = i_req_access[i*2 +: 2];
                w_sel_address    = i_req_address[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
                w_sel_write_data = i_req_write_data[i*BUS_WIDTH +: BUS_WIDTH];
                w_sel_strobe     = i_req_strobe[i*c_strobe_width +: c_strobe_width];
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ARB_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ARB_IDLE:    if (w_any_valid) w_state_next = ARB_BUSY;
            ARB_BUSY:    if (i_bus_ready) w_state_next = ARB_RESPOND;
            ARB_RESPOND: w_state_next = ARB_IDLE;
            default:     w_state_next = ARB_IDLE;
        endcase
    end

    // Command is frozen at grant; the grant itself is dropped as the response is returned.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_grant          <= '0;
            r_last_grant     <= c_last_grant_init;
            r_bus_valid      <= 1'b0;
            r_bus_access     <= '0;
            r_bus_address    <= '0;
            r_bus_write_data <= '0;
            r_bus_strobe     <= '0;
            r_req_ready      <= '0;
            r_req_status     <= '0;
            r_req_read_data  <= '0;
        end else begin
            r_req_ready <= '0;
            case (r_state)
                ARB_IDLE: begin
                    if (w_any_valid) begin
                        r_grant          <= w_winner;
                        r_last_grant     <= w_winner;
                        r_bus_valid      <= 1'b1;
                        r_bus_access     <= w_sel_access;
                        r_bus_address    <= w_sel_address;
                        r_bus_write_data <= w_sel_write_data;
                        r_bus_strobe     <= w_sel_strobe;
                    end
                end
                ARB_BUSY: begin
                    if (i_bus_ready) begin
                        r_bus_valid     <= 1'b0;
                        r_req_ready     <= r_grant;
                        r_req_status    <= i_bus_status;
                        r_req_read_data <= i_bus_read_data;
                        r_grant         <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_grant          = r_grant;
    assign o_bus_valid      = r_bus_valid;
    assign o_bus_access     = r_bus_access;
    assign o_bus_address    = r_bus_address;
    assign o_bus_write_data = r_bus_write_data;
    assign o_bus_strobe     = r_bus_strobe;
    assign o_req_ready      = r_req_ready;
    assign o_req_status     = r_req_status;
    assign o_req_read_data  = r_req_read_data;

endmodule

`default_nettype wire

// File: tb/tb_rggen_bus_arbiter.sv
// ============================================================================
// Module   : tb_rggen_bus_arbiter
// Brief    : Directed self-checking bench for the round-robin register-bus arbiter.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_rggen_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          checks = 0;
    int          errors = 0;

    // Two-requester instance
    logic [1:0]  req_valid  = '0;
    logic [3:0]  req_access = '0;
    logic [15:0] req_addr   = '0;
    logic [63:0] req_wdata  = '0;
    logic [7:0]  req_strobe = '0;
    logic [1:0]  req_ready;
    logic [1:0]  req_status;
    logic [31:0] req_rdata;
    logic        bus_valid;
    logic [1:0]  bus_access;
    logic [7:0]  bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_strobe;
    logic        bus_ready  = 1'b0;
    logic [1:0]  bus_status = '0;
    logic [31:0] bus_rdata  = '0;
    logic [1:0]  grant;

    // Four-requester instance
    logic [3:0]   v4         = '0;
    logic [7:0]   access4    = 8'hAA;
    logic [31:0]  addr4      = 32'h33_22_11_00;
    logic [127:0] wdata4     = '0;
    logic [15:0]  strobe4    = '0;
    logic [3:0]   ready4;
    logic [1:0]   status4;
    logic [31:0]  rdata4;
    logic         bvalid4;
    logic [1:0]   baccess4;
    logic [7:0]   baddr4;
    logic [31:0]  bwdata4;
    logic [3:0]   bstrobe4;
    logic         bready4    = 1'b0;
    logic [3:0]   grant4;

    always #5 clk = ~clk;

    rggen_bus_arbiter #(.REQUESTERS(2), .ADDRESS_WIDTH(8), .BUS_WIDTH(32)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_req_valid(req_valid), .i_req_access(req_access), .i_req_address(req_addr),
        .i_req_write_data(req_wdata), .i_req_strobe(req_strobe),
        .o_req_ready(req_ready), .o_req_status(req_status), .o_req_read_data(req_rdata),
        .o_bus_valid(bus_valid), .o_bus_access(bus_access), .o_bus_address(bus_addr),
        .o_bus_write_data(bus_wdata), .o_bus_strobe(bus_strobe),
        .i_bus_ready(bus_ready), .i_bus_status(bus_status), .i_bus_read_data(bus_rdata),
        .o_grant(grant)
    );

    rggen_bus_arbiter #(.REQUESTERS(4), .ADDRESS_WIDTH(8), .BUS_WIDTH(32)) dut4 (
        .i_clk(clk), .i_rst(rst),
        .i_req_valid(v4), .i_req_access(access4), .i_req_address(addr4),
        .i_req_write_data(wdata4), .i_req_strobe(strobe4),
        .o_req_ready(ready4), .o_req_status(status4), .o_req_read_data(rdata4),
        .o_bus_valid(bvalid4), .o_bus_access(baccess4), .o_bus_address(baddr4),
        .o_bus_write_data(bwdata4), .o_bus_strobe(bstrobe4),
        .i_bus_ready(bready4), .i_bus_status(2'b00), .i_bus_read_data(32'h0000_0044),
        .o_grant(grant4)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        // Reset state
        step();
        check("rst_bus_valid", bus_valid, 0);
        check("rst_bus_addr", bus_addr, 0);
        check("rst_req_ready", req_ready, 0);
        check("rst_req_rdata", req_rdata, 0);
        check("rst_grant", grant, 0);
        check("rst_grant4", grant4, 0);
        rst = 1'b0;

        // Single read from requester 0, downstream ready two cycles after valid
        req_valid = 2'b01; req_access[1:0] = 2'b10; req_addr[7:0] = 8'h10;
        step();
        check("rd_bus_valid", bus_valid, 1);
        check("rd_bus_addr", bus_addr, 8'h10);
        check("rd_bus_access", bus_access, 2'b10);
        check("rd_grant", grant, 2'b01);
        check("rd_no_ready_yet", req_ready, 0);
        step();
        check("rd_bus_valid_hold", bus_valid, 1);
        bus_ready = 1'b1; bus_rdata = 32'hDEADBEEF; bus_status = 2'b00;
        step();
        check("rd_req_ready", req_ready, 2'b01);
        check("rd_req_rdata", req_rdata, 32'hDEADBEEF);
        check("rd_req_status", req_status, 0);
        check("rd_bus_valid_drop", bus_valid, 0);
        check("rd_grant_clear", grant, 0);
        req_valid = 2'b00; bus_ready = 1'b0;
        step();
        check("rd_ready_width", req_ready, 0);
        check("rd_rdata_hold", req_rdata, 32'hDEADBEEF);

        // Fairness from a fresh reset, downstream always ready
        rst = 1'b1;
        step();
        rst = 1'b0;
        req_valid = 2'b11; req_access = 4'b1010; req_addr = 16'h30_20; bus_ready = 1'b1;
        for (int t = 0; t < 4; t++) begin
            bus_rdata = 32'h1000 + t;
            step();
            check("fair_grant", grant, (t % 2 == 0) ? 2'b01 : 2'b10);
            check("fair_addr", bus_addr, (t % 2 == 0) ? 8'h20 : 8'h30);
            step();
            check("fair_ready", req_ready, (t % 2 == 0) ? 2'b01 : 2'b10);
            check("fair_rdata", req_rdata, 32'h1000 + t);
            step();
            check("fair_idle_ready", req_ready, 0);
            check("fair_idle_grant", grant, 0);
        end
        req_valid = 2'b00; bus_ready = 1'b0;
        step();

        // Command stability plus error status on a write from requester 1
        req_valid = 2'b10; req_access[3:2] = 2'b11; req_addr[15:8] = 8'h24;
        req_wdata[63:32] = 32'hA5A5A5A5; req_strobe[7:4] = 4'hF;
        step();
        check("wr_grant", grant, 2'b10);
        check("wr_bus_access", bus_access, 2'b11);
        check("wr_bus_addr", bus_addr, 8'h24);
        check("wr_bus_wdata", bus_wdata, 32'hA5A5A5A5);
        check("wr_bus_strobe", bus_strobe, 4'hF);
        req_addr[15:8] = 8'h00; req_wdata[63:32] = '0; req_strobe[7:4] = '0;
        step();
        check("wr_addr_stable", bus_addr, 8'h24);
        check("wr_wdata_stable", bus_wdata, 32'hA5A5A5A5);
        step();
        check("wr_addr_stable2", bus_addr, 8'h24);
        bus_ready = 1'b1; bus_status = 2'b10; bus_rdata = 32'h12345678;
        step();
        check("err_ready", req_ready, 2'b10);
        check("err_status", req_status, 2'b10);
        check("err_rdata", req_rdata, 32'h12345678);
        req_valid = 2'b00; bus_ready = 1'b0; bus_status = 2'b00;
        step();
        check("err_status_hold", req_status, 2'b10);
        check("err_ready_drop", req_ready, 0);

        // Reset while BUSY on a requester-0 grant
        req_valid = 2'b01; req_access = 4'b1010; req_addr = 16'h50_40;
        step();
        check("mid_grant", grant, 2'b01);
        check("mid_bus_valid", bus_valid, 1);
        bus_ready = 1'b1;
        rst = 1'b1;
        #1;
        check("mid_rst_bus_valid", bus_valid, 0);
        check("mid_rst_bus_addr", bus_addr, 0);
        check("mid_rst_grant", grant, 0);
        check("mid_rst_status", req_status, 0);
        bus_ready = 1'b0;
        req_valid = 2'b11;
        step();
        check("mid_rst_no_ready", req_ready, 0);
        rst = 1'b0;
        step();
        check("post_rst_both_grant", grant, 2'b01);
        check("post_rst_addr", bus_addr, 8'h40);
        bus_ready = 1'b1;
        step();
        check("post_rst_ready", req_ready, 2'b01);
        req_valid = 2'b10; bus_ready = 1'b0;
        step();
        step();
        check("post_rst_req1_grant", grant, 2'b10);
        check("post_rst_req1_addr", bus_addr, 8'h50);
        bus_ready = 1'b1;
        step();
        check("post_rst_req1_ready", req_ready, 2'b10);
        req_valid = 2'b00; bus_ready = 1'b0;
        step();

        // Four requesters: wrap from last grant 3, then from last grant 2
        v4 = 4'b0101; bready4 = 1'b1;
        step();
        check("wrap_grant0", grant4, 4'b0001);
        check("wrap_addr0", baddr4, 8'h00);
        step();
        check("wrap_ready0", ready4, 4'b0001);
        step();
        step();
        check("wrap_grant2", grant4, 4'b0100);
        check("wrap_addr2", baddr4, 8'h22);
        step();
        check("wrap_ready2", ready4, 4'b0100);
        v4 = 4'b1010;
        step();
        step();
        check("wrap_grant3", grant4, 4'b1000);
        step();
        step();
        step();
        check("wrap_grant1", grant4, 4'b0010);
        step();
        check("wrap_ready1", ready4, 4'b0010);
        check("wrap_rdata", rdata4, 32'h44);
        v4 = 4'b0000; bready4 = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
